serial_twos_comp_framed: RTL and testbench

- Parametrised successor of the single-bit serial two's-complement inverter.
- Accepts WIDTH-bit signed words LSB-first, one bit per clock, under a valid/ready handshake.
- Buffers each word and emits it LSB-first in one of four per-word modes: pass, wrapping negate, absolute value, saturating negate.
- Flags overflow on the most-negative input.
- Sits between a serial bit source and a downstream serial consumer.

---
 rtl/serial_twos_comp_framed.sv | 85 ++++++++
 tb/tb_serial_twos_comp_framed.sv | 113 +++++++++++
 2 files changed

// File: rtl/serial_twos_comp_framed.sv
// serial_twos_comp_framed: buffers LSB-first serial words and re-emits them as pass, negate, abs or saturating negate
module serial_twos_comp_framed #(
  parameter int WIDTH = 8
) (
  input  logic t_clk,
  input  logic r_n,
  input  logic in_valid,
  input  logic in_bit,
  input  logic [1:0] in_mode,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  output logic out_ovf,
  input  logic out_ready
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic {FILL, EMIT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [1:0] mode_q, mode_d;
  logic seen_q, seen_d, neg_q, neg_d, sat_q, sat_d, min_q, min_d;
  logic last, emit, cur, sign, is_min;
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= FILL;
      cnt_q <= '0;
      buf_q <= '0;
      mode_q <= '0;
      seen_q <= 1'b0;
      neg_q <= 1'b0;
      sat_q <= 1'b0;
      min_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      mode_q <= mode_d;
      seen_q <= seen_d;
      neg_q <= neg_d;
      sat_q <= sat_d;
      min_q <= min_d;
    end
  end
  // sign and is_min look at buf_d so the final incoming bit is included
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    mode_d = mode_q;
    seen_d = seen_q;
    neg_d = neg_q;
    sat_d = sat_q;
    min_d = min_q;
    last = cnt_q == LAST;
    emit = state_q == EMIT;
    cur = buf_q[cnt_q];
    if (!emit && in_valid) begin
      buf_d[cnt_q] = in_bit;
      mode_d = cnt_q == '0 ? in_mode : mode_q;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
    sign = buf_d[WIDTH-1];
    is_min = buf_d == MIN;
    if (!emit && in_valid && last) begin
      state_d = EMIT;
      min_d = is_min;
      neg_d = mode_q[0] || (mode_q == 2'b10 && sign);
      sat_d = is_min && (mode_q == 2'b11 || (mode_q == 2'b10 && sign));
    end
    if (emit && out_ready) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      seen_d = !last && (seen_q || cur);
      state_d = last ? FILL : EMIT;
    end
    in_ready = !emit;
    out_valid = emit;
    out_last = emit && last;
    out_ovf = emit && min_q && neg_q;
    out_bit = emit && (sat_q ? !last : (neg_q && seen_q) ? !cur : cur);
  end
endmodule

// File: tb/tb_serial_twos_comp_framed.sv
// tb_serial_twos_comp_framed: directed table of words plus reset and backpressure sequences
module tb_serial_twos_comp_framed;
  logic t_clk = 0, r_n = 0, in_valid = 0, in_bit = 0, out_ready = 1;
  logic [1:0] in_mode = 0;
  logic in_ready, out_valid, out_bit, out_last, out_ovf;
  int total = 0, bad = 0;
  typedef struct {
    logic [1:0] mode;
    logic [3:0] data;
    logic [3:0] exp;
    logic ovf;
    logic gaps;
    logic stall;
  } vec_t;
  vec_t vecs[12];
  serial_twos_comp_framed #(.WIDTH(4)) dut (
    .t_clk(t_clk), .r_n(r_n), .in_valid(in_valid), .in_bit(in_bit), .in_mode(in_mode),
    .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .out_ovf(out_ovf), .out_ready(out_ready)
  );
  always #5 t_clk = ~t_clk;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic send_word(input logic [1:0] mode, input logic [3:0] data, input logic gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        @(negedge t_clk);
        in_valid = 0;
        in_mode = ~mode;
      end
      @(negedge t_clk);
      chk("in_ready_fill", {3'b0, in_ready}, 4'd1);
      in_valid = 1;
      in_bit = data[i];
      in_mode = i == 0 ? mode : ~mode;
    end
    @(negedge t_clk);
    in_valid = 0;
    in_bit = 0;
    chk("first_out_latency", {3'b0, out_valid}, 4'd1);
    chk("in_ready_emit", {3'b0, in_ready}, 4'd0);
  endtask
  task automatic recv_word(input logic [3:0] exp, input logic ovf, input logic stall, input int stop);
    logic [3:0] got;
    got = '0;
    for (int i = 0; i < stop; i++) begin
      chk("out_valid", {3'b0, out_valid}, 4'd1);
      chk("out_last", {3'b0, out_last}, {3'b0, i == 3});
      got[i] = out_bit;
      if (i == 3) chk("out_ovf", {3'b0, out_ovf}, {3'b0, ovf});
      if (stall && i == 2) begin
        out_ready = 0;
        repeat (3) begin
          @(negedge t_clk);
          chk("hold_bit", {3'b0, out_bit}, {3'b0, exp[2]});
          chk("hold_last", {3'b0, out_last}, 4'd0);
          chk("hold_in_ready", {3'b0, in_ready}, 4'd0);
        end
        out_ready = 1;
      end
      @(negedge t_clk);
    end
    if (stop == 4) begin
      chk("word", got, exp);
      chk("done_valid", {3'b0, out_valid}, 4'd0);
      chk("done_ready", {3'b0, in_ready}, 4'd1);
    end
  endtask
  initial begin
    vecs[0]  = '{2'b00, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 4'b0110, 4'b1010, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 4'b1000, 4'b0111, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 4'b1000, 4'b0111, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 4'b1101, 4'b0011, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b11, 4'b0011, 4'b1101, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 4'b0110, 4'b1010, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{2'b10, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b1};
    #1;
    chk("rst_out_valid", {3'b0, out_valid}, 4'd0);
    chk("rst_outs", {1'b0, out_bit, out_last, out_ovf}, 4'd0);
    @(negedge t_clk);
    r_n = 1;
    @(negedge t_clk);
    chk("rst_in_ready", {3'b0, in_ready}, 4'd1);
    for (int v = 0; v < 12; v++) begin
      send_word(vecs[v].mode, vecs[v].data, vecs[v].gaps);
      recv_word(vecs[v].exp, vecs[v].ovf, vecs[v].stall, 4);
    end
    send_word(2'b00, 4'b1111, 1'b0);
    recv_word(4'b1111, 1'b0, 1'b0, 2);
    r_n = 0;
    #1;
    chk("midrst_valid", {3'b0, out_valid}, 4'd0);
    @(negedge t_clk);
    r_n = 1;
    @(negedge t_clk);
    chk("postrst_valid", {3'b0, out_valid}, 4'd0);
    chk("postrst_ready", {3'b0, in_ready}, 4'd1);
    send_word(2'b01, 4'b0011, 1'b0);
    recv_word(4'b1101, 1'b0, 1'b0, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
